// File: rtl/sync_ram_pkg.sv
// Shared types and default widths for the burst RAM controller.
package sync_ram_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_LEN_WIDTH  = 4;
  localparam int STATS_W        = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (v == '1) ? v : v + STATS_W'(1);
  endfunction

endpackage

// File: rtl/sync_ram_burst_ctrl_if.sv
// Client and RAM-port signal bundle for sync_ram_burst_ctrl.
interface sync_ram_burst_ctrl_if
  import sync_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
);

  // Handshakes: a request transfers on a cycle where req_valid && req_ready,
  // a write beat on a cycle where wr_valid && wr_ready; rd_valid and done are
  // single-cycle strobes with no backpressure, so the client must take them.
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LEN_WIDTH-1:0]  req_len;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  done;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_dout;

  modport master (
    output req_valid, req_we, req_addr, req_len, wr_valid, wr_data,
    input  req_ready, wr_ready, rd_valid, rd_data, done
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_len, wr_valid, wr_data, ram_dout,
    output req_ready, wr_ready, rd_valid, rd_data, done, ram_we, ram_addr, ram_din
  );

  modport mem (
    input  ram_we, ram_addr, ram_din,
    output ram_dout
  );

endinterface

// File: rtl/sync_ram_burst_addr_gen.sv
// Burst address generator: loads start address and length, steps modulo
// depth, and flags the final beat. The address holds on the final step.
module sync_ram_burst_addr_gen #(
  parameter int ADDR_WIDTH = 4,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_start_addr,
  input  logic [LEN_WIDTH-1:0]  i_len,
  input  logic                  i_step,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_last
);

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_count;
  logic                  w_last;

  assign w_last = (r_count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_addr  <= i_start_addr;
      r_count <= i_len;
    end else if (i_step && !w_last) begin
      // Keeping the last issued address lets the idle RAM port hold it.
      r_addr  <= r_addr + ADDR_WIDTH'(1);
      r_count <= r_count - LEN_WIDTH'(1);
    end
  end

  assign o_addr = r_addr;
  assign o_last = w_last;

endmodule

// File: rtl/synchronous_ram.sv
// Single-port synchronous RAM, read-first; dout valid the cycle after addr.
module synchronous_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] r_dout;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= din;
    end
    r_dout <= r_mem[addr];
  end

  assign dout = r_dout;

endmodule

// File: rtl/sync_ram_burst_ctrl.sv
// Burst initiator for a single-port synchronous RAM.
// Optional beat counters are built when SYNC_RAM_CTRL_STATS_EN is defined.
module sync_ram_burst_ctrl
  import sync_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sync_ram_burst_ctrl_if.slave bus,
  output state_t               o_dbg_state
`ifdef SYNC_RAM_CTRL_STATS_EN
  ,
  output logic [STATS_W-1:0]   wr_beat_cnt,
  output logic [STATS_W-1:0]   rd_beat_cnt
`endif
);

  state_t                r_state;
  state_t                w_next;
  logic                  r_rd_valid;
  logic                  r_done;
  logic                  w_done_set;
  logic                  w_accept;
  logic                  w_step;
  logic                  w_last;
  logic [ADDR_WIDTH-1:0] w_cur_addr;
  logic                  w_req_ready;
  logic                  w_wr_ready;
  logic                  w_ram_we;
  logic [DATA_WIDTH-1:0] w_ram_din;

  assign w_accept = (r_state == IDLE) && bus.req_valid;

  sync_ram_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_addr_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (w_accept),
    .i_start_addr (bus.req_addr),
    .i_len        (bus.req_len),
    .i_step       (w_step),
    .o_addr       (w_cur_addr),
    .o_last       (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_rd_valid <= (r_state == READ);
      r_done     <= w_done_set;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_step      = 1'b0;
    w_done_set  = 1'b0;
    w_req_ready = 1'b0;
    w_wr_ready  = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_din   = '0;
    case (r_state)
      IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) begin
          w_next = bus.req_we ? WRITE : READ;
        end
      end
      WRITE: begin
        w_wr_ready = 1'b1;
        w_ram_we   = bus.wr_valid;
        w_ram_din  = bus.wr_data;
        if (bus.wr_valid) begin
          w_step = 1'b1;
          if (w_last) begin
            w_next     = IDLE;
            w_done_set = 1'b1;
          end
        end
      end
      READ: begin
        // Reads never stall: one address issue per cycle.
        w_step = 1'b1;
        if (w_last) begin
          w_next     = IDLE;
          w_done_set = 1'b1;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign bus.req_ready = w_req_ready;
  assign bus.wr_ready  = w_wr_ready;
  assign bus.ram_we    = w_ram_we;
  assign bus.ram_addr  = w_cur_addr;
  assign bus.ram_din   = w_ram_din;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_data   = bus.ram_dout;
  assign bus.done      = r_done;
  assign o_dbg_state   = r_state;

`ifdef SYNC_RAM_CTRL_STATS_EN
  logic [STATS_W-1:0] r_wr_cnt;
  logic [STATS_W-1:0] r_rd_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (w_ram_we) begin
        r_wr_cnt <= sat_inc(r_wr_cnt);
      end
      if (r_rd_valid) begin
        r_rd_cnt <= sat_inc(r_rd_cnt);
      end
    end
  end

  assign wr_beat_cnt = r_wr_cnt;
  assign rd_beat_cnt = r_rd_cnt;
`endif

endmodule

// File: tb/tb_sync_ram_burst_ctrl.sv
// Bench for sync_ram_burst_ctrl with a synchronous_ram behind it; expected
// RAM contents and beat timing come from a transaction-level model.
module tb_sync_ram_burst_ctrl;
  import sync_ram_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int LW    = 4;
  localparam int DEPTH = 1 << AW;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] exp_q[$];
  int            wr_cnt_m = 0;
  int            rd_cnt_m = 0;

  sync_ram_burst_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

`ifdef SYNC_RAM_CTRL_STATS_EN
  logic [STATS_W-1:0] wr_beat_cnt;
  logic [STATS_W-1:0] rd_beat_cnt;
`endif

  sync_ram_burst_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
`ifdef SYNC_RAM_CTRL_STATS_EN
    ,
    .wr_beat_cnt (wr_beat_cnt),
    .rd_beat_cnt (rd_beat_cnt)
`endif
  );

  synchronous_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_ram (
    .clk  (clk),
    .we   (bus.ram_we),
    .addr (bus.ram_addr),
    .din  (bus.ram_din),
    .dout (bus.ram_dout)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Scoreboard compare
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drivers
  task automatic start_req(input bit we, input int addr, input int len);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = AW'(addr);
    bus.req_len   = LW'(len);
    @(negedge clk);
    chk("req_ready_idle", bus.req_ready, 1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom_range(0, 1));
    bus.req_addr  = AW'($urandom);
    bus.req_len   = LW'($urandom);
  endtask

  // mode: 0 = wr_valid always high, 1 = toggle starting high, 2 = random
  task automatic write_burst(input int addr, input int len, input int mode,
                             input bit use_base, input logic [DW-1:0] base);
    int            beats;
    int            k;
    int            cyc;
    bit            v;
    logic [DW-1:0] d;
    beats = len + 1;
    k     = 0;
    cyc   = 0;
    while (k < beats && cyc < 200) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = (cyc >= 100) ? 1'b1 : 1'($urandom_range(0, 1));
      endcase
      d = use_base ? base + DW'(k) : DW'($urandom);
      bus.wr_valid = v;
      bus.wr_data  = d;
      @(negedge clk);
      chk("wr_ready", bus.wr_ready, 1);
      chk("wr_ram_we", bus.ram_we, v);
      chk("wr_no_done", bus.done, 0);
      if (v) begin
        chk("wr_ram_addr", bus.ram_addr, (addr + k) % DEPTH);
        chk("wr_ram_din", bus.ram_din, d);
      end
      @(posedge clk);
      #1;
      if (v) begin
        model_mem[(addr + k) % DEPTH] = d;
        k++;
        wr_cnt_m++;
      end
      cyc++;
    end
    bus.wr_valid = 1'b0;
    bus.wr_data  = DW'($urandom);
    @(negedge clk);
    chk("wr_done", bus.done, 1);
    chk("wr_done_ram_we", bus.ram_we, 0);
    chk("wr_done_req_ready", bus.req_ready, 1);
    chk("wr_done_wr_ready", bus.wr_ready, 0);
    @(posedge clk);
    #1;
  endtask

  // Called in the first issue cycle; optionally presents the next read in the done cycle.
  task automatic read_burst(input int addr, input int len, input bit chain,
                            input int caddr, input int clen);
    int            beats;
    logic [DW-1:0] e;
    beats = len + 1;
    for (int j = 0; j < beats; j++) begin
      exp_q.push_back(model_mem[(addr + j) % DEPTH]);
    end
    for (int i = 0; i <= beats; i++) begin
      bus.wr_valid = 1'($urandom_range(0, 1));
      bus.wr_data  = DW'($urandom);
      if (i == beats && chain) begin
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = AW'(caddr);
        bus.req_len   = LW'(clen);
      end
      @(negedge clk);
      if (i < beats) begin
        chk("rd_ram_we", bus.ram_we, 0);
        chk("rd_ram_addr", bus.ram_addr, (addr + i) % DEPTH);
      end
      chk("rd_wr_ready", bus.wr_ready, 0);
      chk("rd_valid", bus.rd_valid, (i > 0) ? 1 : 0);
      if (i > 0 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        rd_cnt_m++;
        chk("rd_data", bus.rd_data, e);
      end
      chk("rd_done", bus.done, (i == beats) ? 1 : 0);
      if (i == beats) begin
        chk("rd_done_req_ready", bus.req_ready, 1);
      end
      @(posedge clk);
      #1;
    end
    bus.wr_valid  = 1'b0;
    bus.req_valid = 1'b0;
  endtask

  // Directed then random sequence
  initial begin
    logic [DW-1:0] d;
    bit            we;
    bit            ch;
    int            a;
    int            l;
    int            ca;
    int            cl;

    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    rst_n         = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ram_we", bus.ram_we, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_wr_ready", bus.wr_ready, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_ram_din", bus.ram_din, 0);
    chk("rst_state", dbg_state, IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full-depth fill (len all-ones = 16 beats)
    start_req(1'b1, 0, 15);
    write_burst(0, 15, 0, 1'b0, '0);

    start_req(1'b1, 2, 3);
    write_burst(2, 3, 0, 1'b1, 8'hA0);
    start_req(1'b0, 2, 3);
    read_burst(2, 3, 1'b0, 0, 0);

    // Wrapping write with gaps, then back-to-back reads
    start_req(1'b1, 14, 2);
    write_burst(14, 2, 1, 1'b1, 8'hB0);
    start_req(1'b0, 14, 2);
    read_burst(14, 2, 1'b1, 0, 0);
    read_burst(0, 0, 1'b0, 0, 0);

    // Reset during the second beat of a 4-beat write
    start_req(1'b1, 8, 3);
    d = DW'($urandom);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    @(negedge clk);
    chk("rstw_beat0_we", bus.ram_we, 1);
    @(posedge clk);
    #1;
    model_mem[8] = d;
    bus.wr_data  = ~d;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstw_ram_we", bus.ram_we, 0);
    chk("rstw_ram_addr", bus.ram_addr, 0);
    chk("rstw_ram_din", bus.ram_din, 0);
    chk("rstw_done", bus.done, 0);
    chk("rstw_wr_ready", bus.wr_ready, 0);
    chk("rstw_req_ready", bus.req_ready, 1);
    bus.wr_valid = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    wr_cnt_m = 0;
    rd_cnt_m = 0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rstw_after_done", bus.done, 0);
    chk("rstw_after_rd_valid", bus.rd_valid, 0);
    chk("rstw_after_req_ready", bus.req_ready, 1);
    @(posedge clk);
    #1;
    start_req(1'b0, 8, 3);
    read_burst(8, 3, 1'b0, 0, 0);

    // Random bursts against the model
    for (int t = 0; t < 24; t++) begin
      we = 1'($urandom_range(0, 1));
      a  = $urandom_range(0, DEPTH - 1);
      l  = $urandom_range(0, (1 << LW) - 1);
      start_req(we, a, l);
      if (we) begin
        write_burst(a, l, 2, 1'b0, '0);
      end else begin
        ch = 1'($urandom_range(0, 1));
        ca = $urandom_range(0, DEPTH - 1);
        cl = $urandom_range(0, 3);
        read_burst(a, l, ch, ca, cl);
        if (ch) begin
          read_burst(ca, cl, 1'b0, 0, 0);
        end
      end
    end

`ifdef SYNC_RAM_CTRL_STATS_EN
    chk("stats_wr_beats", wr_beat_cnt, wr_cnt_m);
    chk("stats_rd_beats", rd_beat_cnt, rd_cnt_m);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sync_ram_burst_ctrl.md
Name: sync_ram_burst_ctrl

Overview:
- Initiator for the single-port synchronous RAM: turns burst read/write requests into RAM port cycles.
- RAM port driven: ram_we, ram_addr, ram_din; sampled: ram_dout.
- RAM read data is valid one cycle after the address is issued with we=0.
- Sits between a client (DMA or register block) and a synchronous_ram instance with matching DATA_WIDTH/ADDR_WIDTH.

Parameters:
DATA_WIDTH, 8, RAM word width
ADDR_WIDTH, 4, RAM address width; depth = 2**ADDR_WIDTH
LEN_WIDTH, 4, burst length field width; beats = req_len+1 (1..2**LEN_WIDTH)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request valid
req_ready  output  1  controller idle, request accepted when valid&ready
req_we  input  1  1=write burst, 0=read burst
req_addr  input  ADDR_WIDTH  burst start address
req_len  input  LEN_WIDTH  beats minus one
wr_valid  input  1  write beat valid
wr_ready  output  1  write beat accepted when valid&ready
wr_data  input  DATA_WIDTH  write beat data
rd_valid  output  1  read beat valid (single-cycle, no backpressure)
rd_data  output  DATA_WIDTH  read beat data
done  output  1  one-cycle pulse, burst complete
ram_we  output  1  to RAM we
ram_addr  output  ADDR_WIDTH  to RAM addr
ram_din  output  DATA_WIDTH  to RAM din
ram_dout  input  DATA_WIDTH  from RAM dout

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cur_addr=0, beat count=0, rd_valid=0, done=0, ram_we=0. ram_addr=0 and ram_din=0 at outputs.
- FSM states: IDLE, WRITE, READ.
- IDLE:
  - req_ready=1, wr_ready=0, ram_we=0.
  - On req_valid: latch addr/len/we, then go to WRITE (req_we=1) or READ (req_we=0).
- WRITE:
  - wr_ready=1.
  - ram_we=wr_valid, ram_addr=cur_addr, ram_din=wr_data (combinational passthrough).
  - Each accepted beat: cur_addr+1, count-1.
  - Stalls indefinitely while wr_valid=0; ram_we stays 0 during stalls.
  - After the last beat: go to IDLE; done=1 in the following cycle.
- READ:
  - ram_we=0, ram_addr=cur_addr for exactly beats consecutive cycles (no stalls).
  - rd_valid is registered: 1 in each cycle after an issue cycle.
  - rd_data=ram_dout.
  - After the last issue: go to IDLE; done coincides with the last rd_valid.
- Latency:
  - Request accepted in cycle N: first RAM access in N+1.
  - Read: first rd_valid in N+2.
  - Both burst types: done exactly one cycle after the final RAM access.
- Back-to-back: req_ready=1 in the done cycle, so a new request may be accepted there. Read data from the prior burst still completes correctly.
- Address wrap: cur_addr increments modulo 2**ADDR_WIDTH (15 -> 0); no error raised.
- A burst longer than the depth overwrites or re-reads wrapped locations.
- Length arithmetic is in LEN_WIDTH bits; req_len=all-ones gives 2**LEN_WIDTH beats.
- wr_valid is ignored outside WRITE. req_valid is ignored outside IDLE.
- Reset mid-burst aborts immediately:
  - no further RAM writes;
  - beats already written remain in RAM;
  - no done pulse, and no pending rd_valid survives.
- In IDLE the RAM sees we=0 at the held ram_addr (harmless read). ram_addr holds its last value.

Optional Feature:
- Macro: SYNC_RAM_CTRL_STATS_EN.
- Defined:
  - Adds outputs wr_beat_cnt and rd_beat_cnt, each 16 bits.
  - They count accepted write beats and delivered rd_valid beats.
  - Both saturate at 16'hFFFF and are cleared by reset only.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package sync_ram_pkg holds:
  - FSM state enum (IDLE/WRITE/READ);
  - default width localparams;
  - STATS_W=16.
- One natural sub-module: sync_ram_burst_addr_gen (start address load, modulo increment, beat down-counter, last-beat flag).
- Bench instantiates the controller plus synchronous_ram.

Test Plan (DATA_WIDTH=8, ADDR_WIDTH=4, LEN_WIDTH=4):
- Write addr=2, len=3, data 0xA0..0xA3 with wr_valid always 1 -> ram_we high for 4 cycles at addresses 2..5; done one cycle after the last beat; mem[2..5]=A0..A3.
- Read addr=2, len=3 after the above -> rd_valid in 4 consecutive cycles starting 2 cycles after acceptance; rd_data=A0,A1,A2,A3; done with the last beat.
- Write addr=14, len=2 with wr_valid toggling 1,0,1,0,1 -> writes to 14, 15, 0 only on valid cycles; no ram_we during gaps; done after the third beat.
- Read request accepted in the done cycle of a prior read (addr=0, len=0) -> prior last rd_valid intact; new single beat returns mem[0] two cycles later.
- rst_n pulsed low during beat 2 of a 4-beat write -> outputs reset asynchronously; only the first beat(s) present in RAM; no done; req_ready=1 after release.
- With SYNC_RAM_CTRL_STATS_EN defined -> after the above sequences, wr_beat_cnt and rd_beat_cnt equal the accepted and delivered totals.
